// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave register file with decoupled AW/W capture, SLVERR decode and flat register output.
// Optional: define AXIL_RO_LAST_REG_EN to make register NUM_REGS-1 read-only at RESET_VAL.
module axi4lite_regfile_slave #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 2,
  parameter int unsigned           NUM_REGS   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_done, w_done, aw_done_nx, w_done_nx;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [DATA_WIDTH-1:0] w_data_q, wr_data;
  logic [NB-1:0]         w_strb_q, wr_strb;
  logic                  aw_hs, w_hs, b_hs, commit, wr_err;
  logic                  awready_nx, wready_nx, bvalid_nx;
  logic [1:0]            bresp_nx;
  logic                  ar_hs, r_hs, rd_err, arready_nx, rvalid_nx;
  logic [DATA_WIDTH-1:0] rd_word, rdata_nx;
  logic [1:0]            rresp_nx;

  // Write path: the later of AW/W completes the transaction, using live inputs for whichever lands this cycle
  always_comb begin
    aw_hs   = s_axi_awvalid & s_axi_awready;
    w_hs    = s_axi_wvalid & s_axi_wready;
    b_hs    = s_axi_bvalid & s_axi_bready;
    wr_addr = aw_done ? aw_addr_q : s_axi_awaddr;
    wr_data = w_done ? w_data_q : s_axi_wdata;
    wr_strb = w_done ? w_strb_q : s_axi_wstrb;
    wr_err  = ({1'b0, wr_addr} >= (ADDR_WIDTH+1)'(NUM_REGS));
`ifdef AXIL_RO_LAST_REG_EN
    if (wr_addr == ADDR_WIDTH'(NUM_REGS - 1)) wr_err = 1'b1;
`endif
    commit     = 1'b0;
    w_state_nx = w_state;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    awready_nx = s_axi_awready;
    wready_nx  = s_axi_wready;
    bvalid_nx  = s_axi_bvalid;
    bresp_nx   = s_axi_bresp;
    unique case (w_state)
      W_IDLE: begin
        aw_done_nx = aw_done | aw_hs;
        w_done_nx  = w_done | w_hs;
        awready_nx = ~aw_done_nx;
        wready_nx  = ~w_done_nx;
        if (aw_done_nx && w_done_nx) begin
          commit     = 1'b1;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
          awready_nx = 1'b0;
          wready_nx  = 1'b0;
          bvalid_nx  = 1'b1;
          bresp_nx   = wr_err ? 2'b10 : 2'b00;
          w_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_nx  = 1'b0;
          awready_nx = 1'b1;
          wready_nx  = 1'b1;
          w_state_nx = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    ar_hs   = s_axi_arvalid & s_axi_arready;
    r_hs    = s_axi_rvalid & s_axi_rready;
    rd_err  = ({1'b0, s_axi_araddr} >= (ADDR_WIDTH+1)'(NUM_REGS));
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (s_axi_araddr == ADDR_WIDTH'(i)) rd_word = regs[i];
    r_state_nx = r_state;
    arready_nx = s_axi_arready;
    rvalid_nx  = s_axi_rvalid;
    rdata_nx   = s_axi_rdata;
    rresp_nx   = s_axi_rresp;
    unique case (r_state)
      R_IDLE: begin
        arready_nx = 1'b1;
        if (ar_hs) begin
          arready_nx = 1'b0;
          rvalid_nx  = 1'b1;
          rdata_nx   = rd_word;
          rresp_nx   = rd_err ? 2'b10 : 2'b00;
          r_state_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rvalid_nx  = 1'b0;
          arready_nx = 1'b1;
          r_state_nx = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      w_state       <= w_state_nx;
      r_state       <= r_state_nx;
      aw_done       <= aw_done_nx;
      w_done        <= w_done_nx;
      s_axi_awready <= awready_nx;
      s_axi_wready  <= wready_nx;
      s_axi_bvalid  <= bvalid_nx;
      s_axi_bresp   <= bresp_nx;
      s_axi_arready <= arready_nx;
      s_axi_rvalid  <= rvalid_nx;
      s_axi_rdata   <= rdata_nx;
      s_axi_rresp   <= rresp_nx;
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++)
        for (int unsigned b = 0; b < NB; b++)
          if (commit && !wr_err && wr_addr == ADDR_WIDTH'(i) && wr_strb[b])
            regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave: 16-bit data, 3 registers in a 2-bit address space.
// Expectations follow AXIL_RO_LAST_REG_EN when the bench is compiled with it.
module tb_axi4lite_regfile_slave;
`ifdef AXIL_RO_LAST_REG_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif
  localparam logic [15:0] RV = 16'hC35A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [15:0] wdata = '0;
  logic [1:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [15:0] rdata;
  logic [47:0] reg_q, exp_q;
  int          checks = 0;
  int          failures = 0;

  axi4lite_regfile_slave #(
    .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_REGS(3), .RESET_VAL(RV)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s,
                           input logic [1:0] exp_resp, input string tag);
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    check({tag, ".rdy"}, {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, ".bvalid"}, bvalid, 1'b1);
    check({tag, ".bresp"}, bresp, exp_resp);
    check({tag, ".rdy_lo"}, {awready, wready}, 2'b00);
    @(negedge clk);
    check({tag, ".bdone"}, {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [1:0] a, input logic [15:0] exp_d,
                          input logic [1:0] exp_resp, input string tag);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    check({tag, ".arready"}, arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, ".rvalid"}, {rvalid, arready}, 2'b10);
    check({tag, ".rdata"}, rdata, exp_d);
    check({tag, ".rresp"}, rresp, exp_resp);
    @(negedge clk);
    check({tag, ".rdone"}, {rvalid, arready}, 2'b01);
  endtask

  initial begin
    // Reset state
    exp_q = {RV, RV, RV};
    @(negedge clk); @(negedge clk);
    check("rst.readies", {awready, wready, arready}, 3'b000);
    check("rst.valids", {bvalid, rvalid}, 2'b00);
    check("rst.regq", reg_q, exp_q);
    rst = 1'b0;
    #1 check("rel.arready_lo", arready, 1'b0);
    @(negedge clk);
    check("rel.readies_hi", {awready, wready, arready}, 3'b111);

    axi_read(2'd0, RV, 2'b00, "rd0");
    axi_read(2'd1, RV, 2'b00, "rd1");
    axi_read(2'd2, RV, 2'b00, "rd2");
    axi_read(2'd3, 16'h0000, 2'b10, "rd3_unmapped");

    // Same-cycle AW/W to the last register, low lane only
    axi_write(2'd2, 16'h00A5, 2'b01, RO ? 2'b10 : 2'b00, "wr2");
    exp_q[47:32] = RO ? RV : 16'hC3A5;
    check("wr2.regq", reg_q, exp_q);
    axi_read(2'd2, exp_q[47:32], 2'b00, "rd2b");

    // W leads AW by three cycles, high lane only
    @(negedge clk);
    wdata = 16'hBEEF; wstrb = 2'b10; wvalid = 1'b1; bready = 1'b1; awaddr = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wvalid = 1'b0;
      check("wfirst.rdy", {awready, wready}, 2'b10);
      check("wfirst.bvalid", bvalid, 1'b0);
    end
    check("wfirst.pre", reg_q, exp_q);
    wdata = 16'h0000;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst.bvalid", {bvalid, bresp}, 3'b100);
    exp_q[31:16] = 16'hBE5A;
    check("wfirst.regq", reg_q, exp_q);
    @(negedge clk);
    check("wfirst.done", {bvalid, awready, wready}, 3'b011);

    // AW leads W by two cycles
    @(negedge clk);
    awaddr = 2'd0; awvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      awvalid = 1'b0;
      awaddr = 2'd1;
      check("awfirst.rdy", {awready, wready}, 2'b01);
    end
    wdata = 16'h1122; wstrb = 2'b11; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("awfirst.b", {bvalid, bresp}, 3'b100);
    exp_q[15:0] = 16'h1122;
    check("awfirst.regq", reg_q, exp_q);
    @(negedge clk);

    // Read and write hit register 1 on the same edge: read sees the old value
    @(negedge clk);
    awaddr = 2'd1; awvalid = 1'b1; wdata = 16'h7788; wstrb = 2'b01; wvalid = 1'b1;
    araddr = 2'd1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same.rdata", {rvalid, rdata, rresp}, {1'b1, 16'hBE5A, 2'b00});
    check("same.b", {bvalid, bresp}, 3'b100);
    exp_q[31:16] = 16'hBE88;
    check("same.regq", reg_q, exp_q);
    @(negedge clk);

    axi_write(2'd0, 16'hFFFF, 2'b00, 2'b00, "strb0");
    check("strb0.regq", reg_q, exp_q);
    axi_write(2'd3, 16'h0077, 2'b11, 2'b10, "wr3_unmapped");
    check("wr3.regq", reg_q, exp_q);

    // Write response backpressure; a second request stays pending on the bus
    @(negedge clk);
    awaddr = 2'd0; awvalid = 1'b1; wdata = 16'hABCD; wstrb = 2'b11; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awaddr = 2'd1; wdata = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("bp.b", {bvalid, bresp}, 3'b100);
      check("bp.rdy", {awready, wready}, 2'b00);
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("bp.done", {bvalid, awready, wready}, 3'b011);
    exp_q[15:0] = 16'hABCD;
    check("bp.regq", reg_q, exp_q);

    // Read data backpressure
    @(negedge clk);
    araddr = 2'd0; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    araddr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      check("rbp.r", {rvalid, rdata, rresp}, {1'b1, 16'hABCD, 2'b00});
      check("rbp.arready", arready, 1'b0);
      @(negedge clk);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    check("rbp.done", {rvalid, arready}, 2'b01);

    // Reset with both responses outstanding
    @(negedge clk);
    awaddr = 2'd0; awvalid = 1'b1; wdata = 16'h5555; wstrb = 2'b11; wvalid = 1'b1; bready = 1'b0;
    araddr = 2'd1; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("mid.pending", {bvalid, rvalid}, 2'b11);
    rst = 1'b1;
    #1;
    check("mid.valids", {bvalid, rvalid, awready, arready}, 4'b0000);
    exp_q = {RV, RV, RV};
    check("mid.regq", reg_q, exp_q);
    @(negedge clk);
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("mid.rel", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

    axi_write(2'd2, 16'h0011, 2'b11, RO ? 2'b10 : 2'b00, "wr_last");
    exp_q[47:32] = RO ? RV : 16'h0011;
    check("wr_last.regq", reg_q, exp_q);
    axi_read(2'd2, exp_q[47:32], 2'b00, "rd_last");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
